nibble_word_assembler: RTL and testbench
========================================

// Module: nibble_word_assembler
// PURPOSE
//  Reassembles a stream of 4-bit nibbles into one NUM_NIBBLES*4-bit word. It is the
//  inverse of the nibble selector that splits a word into nibbles for the display.
//  It sits between the SD-card byte/nibble source and the word-wide readout registers.
//  Valid/ready on both sides; one-word output buffer so assembly of the next word
//  overlaps a stalled consumer.
// PARAMETERS
//  NUM_NIBBLES  4  nibbles per word (>=2); word width W = 4*NUM_NIBBLES
//  MSB_FIRST    1  1: first nibble -> word[W-1:W-4] (slot NUM_NIBBLES-1, selector 2'b11 end)
//                  0: first nibble -> word[3:0]
// PORTS
//  clock        in   1   single clock, all state on rising edge
//  reset        in   1   synchronous, active-high
//  clear        in   1   drop partially assembled word (held output word unaffected)
//  nibbleIn     in   4   input nibble
//  nibbleValid  in   1   nibbleIn valid
//  nibbleReady  out  1   assembler accepts nibbleIn this cycle
//  wordOut      out  W   assembled word
//  wordValid    out  1   wordOut valid; held until wordReady
//  wordReady    in   1   consumer takes wordOut this cycle
//  busy         out  1   >=1 nibble of an unfinished word captured
// BEHAVIOUR
//  - Accept = nibbleValid && nibbleReady. Transfer = wordValid && wordReady.
//  - Reset (synchronous, active-high) takes priority over all other inputs:
//    wordOut=0, wordValid=0, busy=0, slot counter=first slot, shadow=0.
//  - Slot counter: ceil(log2(NUM_NIBBLES)) bits.
//    MSB_FIRST=1 counts NUM_NIBBLES-1 down to 0; MSB_FIRST=0 counts up.
//  - On accept: shadow[4*slot+:4] <= nibbleIn, and the slot advances.
//    On the last slot: wordOut <= shadow with the final nibble merged, wordValid <= 1,
//    slot returns to the first slot, busy <= 0.
//  - Latency: wordValid rises the cycle after the final nibble is accepted. No bubbles:
//    one nibble per cycle is sustained when wordReady=1.
//  - nibbleReady = !(slot==last && wordValid && !wordReady). Non-final nibbles are always
//    accepted, so the next word fills the shadow while the output is stalled.
//  - Transfer with no final accept in the same cycle: wordValid <= 0; wordOut keeps its value.
//  - Transfer and final accept in the same cycle: wordValid stays 1 and wordOut loads the
//    new word.
//  - Output stability: wordOut/wordValid must not change while wordValid && !wordReady.
//  - clear (no reset): slot -> first, busy -> 0, shadow -> 0.
//    A nibble presented in the same cycle is dropped, and nibbleReady is 0 in that cycle.
//    wordOut/wordValid are untouched.
//  - busy = 1 from the first accepted nibble of a word until its final nibble or clear.
//  - Reset mid-word or with wordValid=1 discards everything; no word is emitted.
//  - nibbleIn is ignored when nibbleValid=0. No X propagation from an idle nibbleIn.
// TESTING
//  1. Reset, then send A,B,C,D with wordReady=1 (MSB_FIRST=1)
//     -> wordOut=16'hABCD, wordValid high for exactly 1 cycle, 1 cycle after D.
//  2. Back-to-back 1,2,3,4,5,6,7,8 every cycle, wordReady=1 -> 16'h1234 then 16'h5678;
//     nibbleReady constant 1.
//  3. wordReady=0 after 16'h1234; send 9,8,7,6 -> 9,8,7 accepted, nibbleReady=0 on 6,
//     wordOut stays 16'h1234. Raise wordReady -> 6 accepted that cycle; next wordOut=16'h9876.
//  4. Send F,E, assert clear, then send 1,2,3,4 -> only 16'h1234 emitted; busy 1->0 at clear.
//  5. Assert reset with wordValid=1 and 2 nibbles buffered -> next cycle wordValid=0,
//     busy=0, wordOut=0; then 0,0,0,1 -> 16'h0001.
//  6. MSB_FIRST=0, NUM_NIBBLES=4: send A,B,C,D -> wordOut=16'hDCBA.
//     Random valid/ready bench: scoreboard matches, no lost or duplicated words.

Source files
------------

// File: rtl/nibble_word_assembler.sv
// nibble_word_assembler
//   Collects a stream of 4-bit nibbles into one NUM_NIBBLES*4-bit word.
//   This is the inverse of the display nibble selector. It sits between the
//   SD-card nibble source and the word-wide readout registers.
//   A shadow register fills with nibbles. A one-word output buffer holds the
//   finished word. The next word can therefore assemble while the consumer stalls.
//
// Parameters
//   NUM_NIBBLES  nibbles per word (>=2)
//   MSB_FIRST    1: the first nibble lands in the top slot; 0: it lands in slot 0
//
// Ports
//   clock        rising-edge clock
//   reset        synchronous, active-high; overrides every other input
//   clear        drops the partial word; the held output word is untouched
//   nibbleIn     input nibble
//   nibbleValid  nibbleIn valid
//   nibbleReady  a nibble is accepted this cycle when nibbleValid is also high
//   wordOut      assembled word
//   wordValid    wordOut valid; held until wordReady
//   wordReady    consumer takes wordOut this cycle
//   busy         at least one nibble of an unfinished word is captured
module nibble_word_assembler #(
  parameter int NUM_NIBBLES = 4,
  parameter bit MSB_FIRST   = 1'b1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear,
  input  logic [3:0]               nibbleIn,
  input  logic                     nibbleValid,
  output logic                     nibbleReady,
  output logic [4*NUM_NIBBLES-1:0] wordOut,
  output logic                     wordValid,
  input  logic                     wordReady,
  output logic                     busy
);

  localparam int W  = 4 * NUM_NIBBLES;
  localparam int SW = (NUM_NIBBLES > 1) ? $clog2(NUM_NIBBLES) : 1;

  localparam logic [SW-1:0] FIRST_SLOT = MSB_FIRST ? SW'(NUM_NIBBLES - 1) : '0;
  localparam logic [SW-1:0] LAST_SLOT  = MSB_FIRST ? '0 : SW'(NUM_NIBBLES - 1);

  logic [SW-1:0] slot;
  logic [SW-1:0] nextSlot;
  logic [W-1:0]  shadow;
  logic [W-1:0]  merged;
  logic          lastSlot;
  logic          accept;
  logic          transfer;

  assign lastSlot = (slot == LAST_SLOT);
  assign nextSlot = MSB_FIRST ? slot - SW'(1) : slot + SW'(1);

  // Only the final nibble can be blocked, and only while the output buffer
  // is full and not draining. Clear always wins over an incoming nibble.
  assign nibbleReady = !clear && !(lastSlot && wordValid && !wordReady);
  assign accept      = nibbleValid && nibbleReady;
  assign transfer    = wordValid && wordReady;

  // This is the shadow with the current nibble dropped into the active slot.
  // It feeds both the shadow update and the completed-word load.
  for (genvar i = 0; i < NUM_NIBBLES; i++) begin : gSlot
    assign merged[4*i +: 4] = (slot == SW'(i)) ? nibbleIn : shadow[4*i +: 4];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      slot      <= FIRST_SLOT;
      shadow    <= '0;
      busy      <= 1'b0;
      wordOut   <= '0;
      wordValid <= 1'b0;
    end else begin
      // A final accept in the same cycle overrides this and keeps wordValid high.
      if (transfer) wordValid <= 1'b0;

      if (clear) begin
        slot   <= FIRST_SLOT;
        shadow <= '0;
        busy   <= 1'b0;
      end else if (accept) begin
        if (lastSlot) begin
          wordOut   <= merged;
          wordValid <= 1'b1;
          slot      <= FIRST_SLOT;
          shadow    <= '0;
          busy      <= 1'b0;
        end else begin
          shadow <= merged;
          slot   <= nextSlot;
          busy   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_nibble_word_assembler.sv
// Bench for nibble_word_assembler. Two instances share one stimulus stream:
// index 1 uses MSB_FIRST=1 and index 0 uses MSB_FIRST=0. A behavioural model
// counts the captured nibbles and builds each word arithmetically. The model is
// compared with both DUTs on every cycle. Hand-computed word sequences pin the model.
module tb_nibble_word_assembler;
  localparam int N = 4;

  logic              clock = 1'b0;
  logic              reset, clear, nibbleValid, wordReady;
  logic [3:0]        nibbleIn;
  logic [1:0]        nRdy, wVld, bsy;
  logic [1:0][15:0]  wOut;

  nibble_word_assembler #(.NUM_NIBBLES(N), .MSB_FIRST(1'b1)) dut1 (
    .clock(clock), .reset(reset), .clear(clear), .nibbleIn(nibbleIn),
    .nibbleValid(nibbleValid), .nibbleReady(nRdy[1]), .wordOut(wOut[1]),
    .wordValid(wVld[1]), .wordReady(wordReady), .busy(bsy[1]));

  nibble_word_assembler #(.NUM_NIBBLES(N), .MSB_FIRST(1'b0)) dut0 (
    .clock(clock), .reset(reset), .clear(clear), .nibbleIn(nibbleIn),
    .nibbleValid(nibbleValid), .nibbleReady(nRdy[0]), .wordOut(wOut[0]),
    .wordValid(wVld[0]), .wordReady(wordReady), .busy(bsy[0]));

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;
  bit checkOn = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [3:0]  mNib [2][N];
  int          mCnt [2];
  logic        mValid [2];
  logic [15:0] mWord [2];

  function automatic logic [15:0] buildWord(input int d);
    logic [15:0] w;
    w = '0;
    for (int k = 0; k < N; k++) begin
      if (d == 1) w = (w << 4) | 16'(mNib[d][k]);
      else        w = w | (16'(mNib[d][k]) << (4 * k));
    end
    return w;
  endfunction

  function automatic logic modelReady(input int d);
    return !clear && !(mCnt[d] == N - 1 && mValid[d] && !wordReady);
  endfunction

  initial begin
    for (int d = 0; d < 2; d++) begin
      mCnt[d] = 0; mValid[d] = 1'b0; mWord[d] = '0;
    end
    forever begin
      @(posedge clock);
      for (int d = 0; d < 2; d++) begin
        logic acc;
        acc = nibbleValid && modelReady(d);
        if (reset) begin
          mCnt[d] = 0; mValid[d] = 1'b0; mWord[d] = '0;
        end else begin
          if (mValid[d] && wordReady) mValid[d] = 1'b0;
          if (clear) mCnt[d] = 0;
          else if (acc) begin
            mNib[d][mCnt[d]] = nibbleIn;
            mCnt[d]++;
            if (mCnt[d] == N) begin
              mWord[d] = buildWord(d);
              mValid[d] = 1'b1;
              mCnt[d] = 0;
            end
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare + transfer log ----------------
  logic [15:0] log1[$], log0[$];

  initial begin
    forever begin
      @(negedge clock);
      if (checkOn) begin
        for (int d = 0; d < 2; d++) begin
          chk($sformatf("wordValid[%0d]", d), 32'(wVld[d]), 32'(mValid[d]));
          chk($sformatf("wordOut[%0d]", d), 32'(wOut[d]), 32'(mWord[d]));
          chk($sformatf("busy[%0d]", d), 32'(bsy[d]), 32'(mCnt[d] != 0));
          chk($sformatf("nibbleReady[%0d]", d), 32'(nRdy[d]), 32'(modelReady(d)));
        end
        if (wVld[1] && wordReady) log1.push_back(wOut[1]);
        if (wVld[0] && wordReady) log0.push_back(wOut[0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic v, input logic [3:0] n, input logic r,
                       input logic c, input logic rs);
    nibbleValid = v; nibbleIn = n; wordReady = r; clear = c; reset = rs;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic cyc(input logic v, input logic [3:0] n, input logic r,
                     input logic c, input logic rs);
    drive(v, n, r, c, rs);
    tick();
  endtask

  logic [15:0] exp1 [7];
  logic [15:0] exp0 [7];

  initial begin
    logic [3:0] t1 [4];
    exp1 = '{16'hABCD, 16'h1234, 16'h5678, 16'h1234, 16'h9876, 16'h1234, 16'h0001};
    exp0 = '{16'hDCBA, 16'h4321, 16'h8765, 16'h4321, 16'h6789, 16'h4321, 16'h1000};
    t1   = '{4'hA, 4'hB, 4'hC, 4'hD};

    drive(0, 0, 1, 0, 1);
    tick(); tick();
    drive(0, 0, 1, 0, 0);
    checkOn = 1'b1;
    #1;
    chk("reset wordValid", 32'(wVld[1]), 0);
    chk("reset wordOut", 32'(wOut[1]), 0);
    chk("reset busy", 32'(bsy[1]), 0);
    tick();

    // 1 + 6: A,B,C,D with wordReady=1
    for (int i = 0; i < 4; i++) cyc(1, t1[i], 1, 0, 0);
    chk("t1 wordValid", 32'(wVld[1]), 1);
    chk("t1 wordOut", 32'(wOut[1]), 32'h ABCD);
    chk("t6 wordOut lsb-first", 32'(wOut[0]), 32'h DCBA);
    cyc(0, 0, 1, 0, 0);
    chk("t1 wordValid one cycle", 32'(wVld[1]), 0);

    // 2: back-to-back 1..8
    for (int i = 1; i <= 8; i++) begin
      drive(1, 4'(i), 1, 0, 0);
      #1 chk("t2 nibbleReady", 32'(nRdy[1]), 1);
      tick();
    end
    cyc(0, 0, 1, 0, 0);

    // 3: stall the output after 1234, then feed 9,8,7,6
    for (int i = 1; i <= 4; i++) cyc(1, 4'(i), 0, 0, 0);
    cyc(1, 4'h9, 0, 0, 0);
    cyc(1, 4'h8, 0, 0, 0);
    cyc(1, 4'h7, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      drive(1, 4'h6, 0, 0, 0);
      #1;
      chk("t3 stall ready", 32'(nRdy[1]), 0);
      chk("t3 stall word", 32'(wOut[1]), 32'h1234);
      tick();
    end
    drive(1, 4'h6, 1, 0, 0);
    #1 chk("t3 release ready", 32'(nRdy[1]), 1);
    tick();
    chk("t3 next word", 32'(wOut[1]), 32'h9876);
    chk("t3 next valid", 32'(wVld[1]), 1);
    cyc(0, 0, 1, 0, 0);

    // 4: F,E then clear (a nibble presented alongside clear is dropped)
    cyc(1, 4'hF, 1, 0, 0);
    cyc(1, 4'hE, 1, 0, 0);
    chk("t4 busy before clear", 32'(bsy[1]), 1);
    drive(1, 4'h7, 1, 1, 0);
    #1 chk("t4 ready during clear", 32'(nRdy[1]), 0);
    tick();
    chk("t4 busy after clear", 32'(bsy[1]), 0);
    for (int i = 1; i <= 4; i++) cyc(1, 4'(i), 1, 0, 0);
    chk("t4 word", 32'(wOut[1]), 32'h1234);
    cyc(0, 0, 1, 0, 0);

    // 5: reset with a held word and two buffered nibbles
    for (int i = 0; i < 4; i++) cyc(1, 4'h5, 0, 0, 0);
    cyc(1, 4'h3, 0, 0, 0);
    cyc(1, 4'h3, 0, 0, 0);
    chk("t5 held valid", 32'(wVld[1]), 1);
    chk("t5 busy", 32'(bsy[1]), 1);
    cyc(0, 0, 0, 0, 1);
    chk("t5 post-reset valid", 32'(wVld[1]), 0);
    chk("t5 post-reset busy", 32'(bsy[1]), 0);
    chk("t5 post-reset word", 32'(wOut[1]), 0);
    cyc(1, 4'h0, 1, 0, 0);
    cyc(1, 4'h0, 1, 0, 0);
    cyc(1, 4'h0, 1, 0, 0);
    cyc(1, 4'h1, 1, 0, 0);
    chk("t5 word", 32'(wOut[1]), 32'h0001);
    cyc(0, 0, 1, 0, 0);

    // Check the transferred sequence of the directed part against hand values.
    chk("log1 count", 32'(log1.size()), 7);
    chk("log0 count", 32'(log0.size()), 7);
    for (int i = 0; i < 7; i++) begin
      if (i < log1.size()) chk($sformatf("log1[%0d]", i), 32'(log1[i]), 32'(exp1[i]));
      if (i < log0.size()) chk($sformatf("log0[%0d]", i), 32'(log0[i]), 32'(exp0[i]));
    end

    // Random valid/ready/clear traffic. The model checks every cycle.
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 9) < 7), 4'($urandom), ($urandom_range(0, 9) < 6),
          ($urandom_range(0, 49) == 0), ($urandom_range(0, 149) == 0));
    end
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
